layer_priority_ctrl: RTL and testbench

Programmable priority arbiter and per-frame scheduler for the VGA object layers. Replaces fixed if/else pixel priority with a rank table, written by game logic over a valid/ready handshake. Table changes are staged in a shadow copy and committed only on the start-of-frame pulse, so a frame never shows a mixed ordering. Sits between the per-object drawing units (request + RGB) and the VGA output, feeding pixel RGB at a fixed 2-cycle latency.

---
 rtl/layer_priority_ctrl.sv | 131 +++++++++++++
 tb/tb_layer_priority_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/layer_priority_ctrl.sv
// layer_priority_ctrl: rank-table pixel arbiter with frame-synchronous shadow commit, 2-cycle RGB pipeline.
// Optional per-layer blinking is built only when LAYER_BLINK_EN is defined.
module layer_priority_ctrl #(
  parameter int NUM_LAYERS   = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [NUM_LAYERS-1:0]   draw_req,
  input  logic [8*NUM_LAYERS-1:0] layer_rgb,
  input  logic [7:0]              bg_rgb,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [2:0]              cfg_layer,
  input  logic [2:0]              cfg_rank,
  input  logic                    cfg_enable,
  input  logic                    cfg_blink,
  output logic [7:0]              rgb_out,
  output logic                    winner_valid,
  output logic [2:0]              winner_id,
  output logic                    cfg_pending
);
  typedef enum logic [1:0] {IDLE, DIRTY, COMMIT} state_t;
  state_t state, state_nx;
  logic [NUM_LAYERS-1:0][2:0] a_rank, s_rank, rank_q;
  logic [NUM_LAYERS-1:0]      a_en, s_en, blink_mask, cand_q;
  logic [8*NUM_LAYERS-1:0]    rgb_q;
  logic [7:0]                 bg_q;
  logic                       wr, found;
  logic [2:0]                 best_rank, best_id;

  assign cfg_ready   = resetN && state != COMMIT;
  assign cfg_pending = state != IDLE;
  assign wr          = cfg_valid && cfg_ready;

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = wr ? DIRTY : IDLE;
      DIRTY:   state_nx = startOfFrame ? COMMIT : DIRTY;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        s_rank[i] <= 3'(i);
        a_rank[i] <= 3'(i);
      end
      s_en <= '1;
      a_en <= '1;
    end else begin
      if (wr) begin
        s_rank[cfg_layer] <= cfg_rank;
        s_en[cfg_layer]   <= cfg_enable;
      end
      if (state == COMMIT) begin
        a_rank <= s_rank;
        a_en   <= s_en;
      end
    end

`ifdef LAYER_BLINK_EN
  logic [7:0]            frame_cnt;
  logic                  blink_phase, frame_wrap;
  logic [NUM_LAYERS-1:0] a_bl, s_bl;
  assign frame_wrap = frame_cnt == 8'(BLINK_FRAMES - 1);
  assign blink_mask = a_bl & {NUM_LAYERS{blink_phase}};
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      s_bl        <= '0;
      a_bl        <= '0;
    end else begin
      if (startOfFrame) begin
        frame_cnt   <= frame_wrap ? 8'd0 : frame_cnt + 8'd1;
        blink_phase <= blink_phase ^ frame_wrap;
      end
      if (wr) s_bl[cfg_layer] <= cfg_blink;
      if (state == COMMIT) a_bl <= s_bl;
    end
`else
  logic unused_blink;
  assign unused_blink = cfg_blink;
  assign blink_mask   = '0;
`endif

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      cand_q <= '0;
      rank_q <= '0;
      rgb_q  <= '0;
      bg_q   <= '0;
    end else begin
      cand_q <= draw_req & a_en & ~blink_mask;
      rank_q <= a_rank;
      rgb_q  <= layer_rgb;
      bg_q   <= bg_rgb;
    end

  // strict less-than while scanning upward keeps the lowest index on rank ties
  always_comb begin
    found     = 1'b0;
    best_rank = 3'd7;
    best_id   = 3'd0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (cand_q[i] && (!found || rank_q[i] < best_rank)) begin
        found     = 1'b1;
        best_rank = rank_q[i];
        best_id   = 3'(i);
      end
  end

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      rgb_out      <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
    end else begin
      rgb_out      <= found ? rgb_q[8*best_id +: 8] : bg_q;
      winner_valid <= found;
      winner_id    <= best_id;
    end
endmodule

// File: tb/tb_layer_priority_ctrl.sv
// tb_layer_priority_ctrl: directed vector table plus hand-written commit, tie, blink and reset sequences.
module tb_layer_priority_ctrl;
`ifdef LAYER_BLINK_EN
  localparam int BF = 2;
`else
  localparam int BF = 16;
`endif
  logic        clk = 0, resetN = 0, startOfFrame = 0, cfg_valid = 0, cfg_ready;
  logic [7:0]  draw_req = 0, bg_rgb = 8'h55, rgb_out;
  logic [63:0] layer_rgb;
  logic [2:0]  cfg_layer = 0, cfg_rank = 0, winner_id;
  logic        cfg_enable = 0, cfg_blink = 0, winner_valid, cfg_pending;
  logic [7:0]  lrgb [8] = '{8'h10, 8'h1C, 8'hE0, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  int          n_run = 0, n_fail = 0;

  typedef struct {logic [7:0] req; logic [7:0] rgb; logic vld; logic [2:0] id;} vec_t;
  vec_t vt [7];

  layer_priority_ctrl #(.NUM_LAYERS(8), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .draw_req(draw_req),
    .layer_rgb(layer_rgb), .bg_rgb(bg_rgb), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_layer(cfg_layer), .cfg_rank(cfg_rank), .cfg_enable(cfg_enable), .cfg_blink(cfg_blink),
    .rgb_out(rgb_out), .winner_valid(winner_valid), .winner_id(winner_id), .cfg_pending(cfg_pending));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] l, input logic [2:0] r, input logic e, input logic b);
    cfg_valid = 1; cfg_layer = l; cfg_rank = r; cfg_enable = e; cfg_blink = b;
    chk("cfg_ready_on_write", cfg_ready, 1);
    tick(1);
    cfg_valid = 0;
  endtask

  task automatic sof_commit();
    startOfFrame = 1;
    tick(1);
    startOfFrame = 0;
    chk("commit_ready_low", cfg_ready, 0);
    tick(1);
    chk("commit_done_ready", cfg_ready, 1);
    chk("commit_done_pending", cfg_pending, 0);
  endtask

  task automatic pix(input string nm, input logic [7:0] req, input logic [7:0] rgb, input logic v, input logic [2:0] id);
    draw_req = req;
    tick(2);
    chk({nm, "_rgb"}, rgb_out, rgb);
    chk({nm, "_valid"}, winner_valid, v);
    chk({nm, "_id"}, winner_id, id);
  endtask

  task automatic sof_only();
    startOfFrame = 1;
    tick(1);
    startOfFrame = 0;
    tick(3);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) layer_rgb[8*i +: 8] = lrgb[i];
    vt[0] = '{8'h06, 8'h1C, 1, 3'd1};
    vt[1] = '{8'h00, 8'h55, 0, 3'd0};
    vt[2] = '{8'h80, 8'h17, 1, 3'd7};
    vt[3] = '{8'h81, 8'h10, 1, 3'd0};
    vt[4] = '{8'hF0, 8'h14, 1, 3'd4};
    vt[5] = '{8'hFF, 8'h10, 1, 3'd0};
    vt[6] = '{8'h28, 8'h13, 1, 3'd3};
    #12;
    chk("rst_rgb", rgb_out, 0);
    chk("rst_valid", winner_valid, 0);
    chk("rst_id", winner_id, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_ready", cfg_ready, 0);
    @(negedge clk) resetN = 1;
    tick(1);
    chk("rel_ready", cfg_ready, 1);
    // back-to-back vectors: output of vector k-1 is visible after the edge following vector k's drive
    for (int k = 0; k <= 7; k++) begin
      if (k < 7) draw_req = vt[k].req;
      tick(1);
      if (k >= 1) begin
        chk("vec_rgb", rgb_out, vt[k-1].rgb);
        chk("vec_valid", winner_valid, vt[k-1].vld);
        chk("vec_id", winner_id, vt[k-1].id);
      end
    end
    pix("base", 8'h06, 8'h1C, 1, 3'd1);
    cfg_write(3'd2, 3'd0, 1, 0);
    tick(2);
    chk("staged_pending", cfg_pending, 1);
    chk("staged_rgb", rgb_out, 8'h1C);
    chk("staged_id", winner_id, 1);
    sof_commit();
    tick(2);
    chk("committed_rgb", rgb_out, 8'hE0);
    chk("committed_id", winner_id, 2);
    cfg_write(3'd7, 3'd7, 1, 0);
    chk("dirty_pending", cfg_pending, 1);
    cfg_valid = 1; cfg_layer = 3'd1; cfg_rank = 3'd1; cfg_enable = 0; cfg_blink = 0;
    startOfFrame = 1;
    chk("sof_write_ready", cfg_ready, 1);
    tick(1);
    cfg_valid = 0; startOfFrame = 0;
    chk("sof_write_commit", cfg_ready, 0);
    tick(1);
    pix("disabled", 8'h02, 8'h55, 0, 3'd0);
    cfg_write(3'd3, 3'd0, 1, 0);
    cfg_write(3'd5, 3'd0, 1, 0);
    sof_commit();
    pix("tie35", 8'h28, 8'h13, 1, 3'd3);
    pix("tie235", 8'h2C, 8'hE0, 1, 3'd2);
    resetN = 0;
    tick(1);
    resetN = 1;
    tick(1);
    cfg_write(3'd0, 3'd0, 1, 1);
    sof_commit();
    pix("blink_f1", 8'h01, 8'h10, 1, 3'd0);
    sof_only();
`ifdef LAYER_BLINK_EN
    chk("blink_f2_rgb", rgb_out, 8'h55);
    chk("blink_f2_valid", winner_valid, 0);
    sof_only();
    chk("blink_f3_rgb", rgb_out, 8'h55);
    sof_only();
    chk("blink_f4_rgb", rgb_out, 8'h10);
    chk("blink_f4_valid", winner_valid, 1);
`else
    chk("noblink_f2_rgb", rgb_out, 8'h10);
    repeat (16) sof_only();
    chk("noblink_late_rgb", rgb_out, 8'h10);
    chk("noblink_late_valid", winner_valid, 1);
`endif
    cfg_write(3'd7, 3'd0, 1, 0);
    chk("pre_rst_pending", cfg_pending, 1);
    resetN = 0;
    #1;
    chk("mid_rst_pending", cfg_pending, 0);
    chk("mid_rst_rgb", rgb_out, 0);
    chk("mid_rst_ready", cfg_ready, 0);
    tick(1);
    resetN = 1;
    tick(1);
    pix("post_rst", 8'h81, 8'h10, 1, 3'd0);
    chk("post_rst_pending", cfg_pending, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
